// File: rtl/mem_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_pkg
// Shared definitions for the memory bus arbiter: FSM state encodings, the
// all-bytes select pattern used for instruction fetches, the grant watchdog
// limit and the word returned to a requester when a grant times out.
// -----------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_D = 2'd1,
    ARB_GNT_I = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_t;

  localparam logic [3:0]  WB_SELECT_ALL     = 4'b1111;
  localparam logic [7:0]  ARB_TIMEOUT_LIMIT = 8'd255;
  localparam logic [31:0] ARB_ERR_WORD      = 32'hDEAD_BEEF;

  // Width of a counter able to hold 0..max (at least one bit).
  function automatic int burst_cnt_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_priority_pick.sv
// -----------------------------------------------------------------------------
// arb_priority_pick
// Combinational requester selection. D wins whenever it requests, unless I is
// also waiting and D has already used up its burst allowance.
//
// Ports:
//   d_req     in   data-path request
//   i_req     in   fetch-path request
//   burst_cnt in   consecutive D grants taken while I was waiting
//   pick_d    out  grant D next
//   pick_i    out  grant I next
// -----------------------------------------------------------------------------
module arb_priority_pick #(
  parameter int CNT_W       = 2,
  parameter int D_BURST_MAX = 2
) (
  input  logic             d_req,
  input  logic             i_req,
  input  logic [CNT_W-1:0] burst_cnt,
  output logic             pick_d,
  output logic             pick_i
);

  logic w_force_i;

  assign w_force_i = (burst_cnt == CNT_W'(D_BURST_MAX));
  assign pick_d    = d_req & ~(i_req & w_force_i);
  assign pick_i    = i_req & ~pick_d;

endmodule

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one external bus port between the data path (D) and the instruction
// fetch path (I). One transaction at a time, req/ack handshake on both sides,
// D prioritised with a burst limit so a waiting fetch always gets through.
// Also produces the pipeline stall requests.
//
// Optional build macro MEM_BUS_ARBITER_TIMEOUT_EN adds an 8-bit grant
// watchdog and the bus_err output; without it a grant waits forever.
//
// Ports:
//   clk, rst                     clock / async active-low reset
//   d_req/d_we/d_addr/d_wdata/d_sel   data request side
//   d_rdata/d_ack                data response (d_ack one-cycle pulse)
//   i_req/i_addr                 fetch request side
//   i_rdata/i_ack                fetch response (i_ack one-cycle pulse)
//   s_cyc/s_we/s_addr/s_wdata/s_sel   registered bus master outputs
//   s_rdata/s_ack                bus slave response
//   bus_err                      (macro only) pulse with the timed-out ack
//   stall_req_if/stall_req_mem   pipeline stall requests
//
// state     | meaning
// ----------+-------------------------------------------------
// ARB_IDLE  | no grant, arbitrate between pending requesters
// ARB_GNT_D | bus cycle running for the data path
// ARB_GNT_I | bus cycle running for the fetch path
// ARB_DONE  | ack pulse visible, requester drops its req
// -----------------------------------------------------------------------------
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int D_BURST_MAX = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_sel,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  output logic              s_cyc,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [3:0]        s_sel,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_ack,
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
  output logic              bus_err,
`endif
  output logic              stall_req_if,
  output logic              stall_req_mem
);

  localparam int CNT_W = burst_cnt_width(D_BURST_MAX);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              w_pick_d;
  logic              w_pick_i;
  logic              w_grant_d;
  logic              w_grant_i;
  logic              w_done;
  logic              w_done_d;
  logic              w_done_i;
  logic [DATA_W-1:0] w_rdata_ret;

  logic              r_s_cyc;
  logic              r_s_we;
  logic [ADDR_W-1:0] r_s_addr;
  logic [DATA_W-1:0] r_s_wdata;
  logic [3:0]        r_s_sel;
  logic              r_d_ack;
  logic              r_i_ack;
  logic [DATA_W-1:0] r_d_rdata;
  logic [DATA_W-1:0] r_i_rdata;
  logic [CNT_W-1:0]  r_burst_cnt;

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
  logic [7:0]        r_wdog;
  logic              r_bus_err;
  logic              w_wdog_expired;
  logic              w_timeout;

  // r_wdog is 0 in the first grant cycle, so the limit-1 compare fires in
  // the limit'th cycle without an ack.
  assign w_wdog_expired = (r_wdog == (ARB_TIMEOUT_LIMIT - 8'd1));
`endif

  arb_priority_pick #(
    .CNT_W       (CNT_W),
    .D_BURST_MAX (D_BURST_MAX)
  ) u_pick (
    .d_req     (d_req),
    .i_req     (i_req),
    .burst_cnt (r_burst_cnt),
    .pick_d    (w_pick_d),
    .pick_i    (w_pick_i)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ARB_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_d   = 1'b0;
    w_grant_i   = 1'b0;
    w_done      = 1'b0;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    w_timeout   = 1'b0;
`endif
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_d) begin
          w_state_nxt = ARB_GNT_D;
          w_grant_d   = 1'b1;
        end else if (w_pick_i) begin
          w_state_nxt = ARB_GNT_I;
          w_grant_i   = 1'b1;
        end
      end
      ARB_GNT_D, ARB_GNT_I: begin
        if (s_ack) begin
          w_state_nxt = ARB_DONE;
          w_done      = 1'b1;
        end
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
        else if (w_wdog_expired) begin
          w_state_nxt = ARB_DONE;
          w_done      = 1'b1;
          w_timeout   = 1'b1;
        end
`endif
      end
      ARB_DONE: w_state_nxt = ARB_IDLE;
      default:  w_state_nxt = ARB_IDLE;
    endcase
  end

  assign w_done_d = w_done & (r_state == ARB_GNT_D);
  assign w_done_i = w_done & (r_state == ARB_GNT_I);

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
  assign w_rdata_ret = w_timeout ? DATA_W'(ARB_ERR_WORD) : s_rdata;
`else
  assign w_rdata_ret = s_rdata;
`endif

  // Bus outputs are captured once at grant and only s_cyc changes afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s_cyc   <= 1'b0;
      r_s_we    <= 1'b0;
      r_s_addr  <= '0;
      r_s_wdata <= '0;
      r_s_sel   <= '0;
      r_d_ack   <= 1'b0;
      r_i_ack   <= 1'b0;
      r_d_rdata <= '0;
      r_i_rdata <= '0;
    end else begin
      r_d_ack <= w_done_d;
      r_i_ack <= w_done_i;
      if (w_done_d) r_d_rdata <= w_rdata_ret;
      if (w_done_i) r_i_rdata <= w_rdata_ret;
      if (w_grant_d) begin
        r_s_cyc   <= 1'b1;
        r_s_we    <= d_we;
        r_s_addr  <= d_addr;
        r_s_wdata <= d_wdata;
        r_s_sel   <= d_sel;
      end else if (w_grant_i) begin
        r_s_cyc   <= 1'b1;
        r_s_we    <= 1'b0;
        r_s_addr  <= i_addr;
        r_s_wdata <= '0;
        r_s_sel   <= WB_SELECT_ALL;
      end else if (w_done) begin
        r_s_cyc   <= 1'b0;
      end
    end
  end

  // Counts D completions taken while I was waiting; once at the limit the
  // pick block forces the next grant to I.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_burst_cnt <= '0;
    end else if (w_done_i) begin
      r_burst_cnt <= '0;
    end else if (w_done_d && i_req) begin
      if (r_burst_cnt < CNT_W'(D_BURST_MAX)) r_burst_cnt <= r_burst_cnt + CNT_W'(1);
    end else if ((r_state == ARB_IDLE) && !i_req) begin
      r_burst_cnt <= '0;
    end
  end

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wdog    <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= w_timeout;
      if (w_grant_d || w_grant_i) r_wdog <= '0;
      else if ((r_state == ARB_GNT_D) || (r_state == ARB_GNT_I)) r_wdog <= r_wdog + 8'd1;
    end
  end

  assign bus_err = r_bus_err;
`endif

  assign s_cyc   = r_s_cyc;
  assign s_we    = r_s_we;
  assign s_addr  = r_s_addr;
  assign s_wdata = r_s_wdata;
  assign s_sel   = r_s_sel;
  assign d_ack   = r_d_ack;
  assign i_ack   = r_i_ack;
  assign d_rdata = r_d_rdata;
  assign i_rdata = r_i_rdata;

  assign stall_req_mem = d_req & ~r_d_ack;
  assign stall_req_if  = i_req & ~r_i_ack;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed stimulus with a queue-based scoreboard. Tests push the expected bus
// grants and acks in order; a negedge monitor pops and compares them as the
// arbiter presents them. Spot checks made by the stimulus are also queued and
// evaluated by the monitor so all counting happens in one process.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_req, d_we, i_req, s_ack;
  logic [31:0] d_addr, d_wdata, i_addr, s_rdata;
  logic [3:0]  d_sel;
  logic [31:0] d_rdata, i_rdata, s_addr, s_wdata;
  logic        d_ack, i_ack, s_cyc, s_we, stall_req_if, stall_req_mem;
  logic [3:0]  s_sel;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
  logic        bus_err;
`endif

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .D_BURST_MAX(2)) dut (
    .clk(clk), .rst(rst),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_sel(d_sel),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .s_cyc(s_cyc), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_sel(s_sel),
    .s_rdata(s_rdata), .s_ack(s_ack),
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    .bus_err(bus_err),
`endif
    .stall_req_if(stall_req_if), .stall_req_mem(stall_req_mem)
  );

  typedef struct { logic is_d; logic [31:0] rdata; logic err; } ack_exp_t;
  typedef struct { logic [31:0] addr; logic we; logic [3:0] sel; logic [31:0] wdata; int len; } bus_exp_t;
  typedef struct { string name; logic [63:0] act; logic [63:0] exp; } chk_t;

  ack_exp_t ack_q[$];
  bus_exp_t bus_q[$];
  chk_t     chk_q[$];
  int       n_checks = 0;
  int       n_errors = 0;

  localparam logic [31:0] ECHO_KEY = 32'h5A5A_0000;

  // ---------------- slave model ----------------
  logic        slave_en = 1'b0;
  logic        slave_echo = 1'b0;
  logic [31:0] slave_data = '0;
  int          slave_wait = 0;
  logic        spur_ack = 1'b0;
  int          wcnt = 0;

  initial begin
    s_ack   = 1'b0;
    s_rdata = '0;
    forever begin
      @(negedge clk);
      s_ack = spur_ack;
      if (s_cyc && slave_en) begin
        if (wcnt == slave_wait) begin
          s_ack   = 1'b1;
          s_rdata = slave_echo ? (s_addr ^ ECHO_KEY) : slave_data;
          wcnt    = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic        prev_cyc = 1'b0;
  logic        cur_valid = 1'b0;
  logic        unstable = 1'b0;
  int          cyc_len = 0;
  bus_exp_t    cur;
  logic [68:0] cap;

  function automatic void cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    chk_t     c;
    ack_exp_t a;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      cmp(c.name, c.act, c.exp);
    end

    if (d_ack || i_ack) begin
      if (ack_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_ack: d_ack=%0b i_ack=%0b, expected no ack", d_ack, i_ack);
      end else begin
        a = ack_q.pop_front();
        cmp("ack_source", {62'd0, d_ack, i_ack}, {62'd0, a.is_d, ~a.is_d});
        cmp(a.is_d ? "d_rdata" : "i_rdata", 64'(a.is_d ? d_rdata : i_rdata), 64'(a.rdata));
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
        cmp("bus_err_with_ack", 64'(bus_err), 64'(a.err));
`endif
      end
    end
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    else if (bus_err) begin
      n_checks++;
      n_errors++;
      $display("FAIL stray_bus_err: bus_err=1 without an ack, expected 0");
    end
`endif

    if (s_cyc && !prev_cyc) begin
      cyc_len  = 1;
      unstable = 1'b0;
      cap      = {s_we, s_sel, s_addr, s_wdata};
      if (bus_q.size() == 0) begin
        n_checks++;
        n_errors++;
        cur_valid = 1'b0;
        $display("FAIL unexpected_grant: s_addr=0x%0h, expected no bus cycle", s_addr);
      end else begin
        cur       = bus_q.pop_front();
        cur_valid = 1'b1;
        cmp("s_addr", 64'(s_addr), 64'(cur.addr));
        cmp("s_we", 64'(s_we), 64'(cur.we));
        cmp("s_sel", 64'(s_sel), 64'(cur.sel));
        if (cur.we) cmp("s_wdata", 64'(s_wdata), 64'(cur.wdata));
      end
    end else if (s_cyc && prev_cyc) begin
      cyc_len++;
      if ({s_we, s_sel, s_addr, s_wdata} !== cap) unstable = 1'b1;
    end else if (!s_cyc && prev_cyc && cur_valid) begin
      cmp("bus_stable", 64'(unstable), 64'd0);
      if (cur.len >= 0) cmp("cyc_len", 64'(cyc_len), 64'(cur.len));
      cur_valid = 1'b0;
    end
    prev_cyc = s_cyc;
  end

  // ---------------- stimulus helpers ----------------
  function automatic void expect_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_q.push_back('{name, act, exp});
  endfunction

  function automatic void exp_bus(input logic [31:0] addr, input logic we, input logic [3:0] sel,
                                  input logic [31:0] wdata, input int len);
    bus_q.push_back('{addr, we, sel, wdata, len});
  endfunction

  function automatic void exp_ack(input logic is_d, input logic [31:0] rdata, input logic err);
    ack_q.push_back('{is_d, rdata, err});
  endfunction

  task automatic d_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] sel, input int bound);
    int n;
    @(posedge clk);
    #1;
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_sel = sel;
    #1;
    expect_eq("stall_mem_pending", 64'(stall_req_mem), 64'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!d_ack && n < bound);
    expect_eq("d_ack_seen", 64'(d_ack), 64'd1);
    expect_eq("stall_mem_at_ack", 64'(stall_req_mem), 64'd0);
    d_req = 1'b0;
  endtask

  task automatic i_xfer(input logic [31:0] addr, input int bound);
    int n;
    @(posedge clk);
    #1;
    i_req = 1'b1; i_addr = addr;
    #1;
    expect_eq("stall_if_pending", 64'(stall_req_if), 64'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!i_ack && n < bound);
    expect_eq("i_ack_seen", 64'(i_ack), 64'd1);
    expect_eq("stall_if_at_ack", 64'(stall_req_if), 64'd0);
    i_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "time limit");
  end

  // ---------------- test sequence ----------------
  initial begin
    int n;
    rst = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_sel = '0;
    i_req = 1'b0; i_addr = '0;
    #1;
    expect_eq("rst_s_cyc", 64'(s_cyc), 64'd0);
    expect_eq("rst_s_we", 64'(s_we), 64'd0);
    expect_eq("rst_s_addr", 64'(s_addr), 64'd0);
    expect_eq("rst_s_wdata", 64'(s_wdata), 64'd0);
    expect_eq("rst_s_sel", 64'(s_sel), 64'd0);
    expect_eq("rst_acks", 64'({d_ack, i_ack}), 64'd0);
    expect_eq("rst_d_rdata", 64'(d_rdata), 64'd0);
    expect_eq("rst_i_rdata", 64'(i_rdata), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    slave_en = 1'b1;

    // D read, zero-wait slave
    slave_echo = 1'b0; slave_data = 32'h1234_5678; slave_wait = 0;
    exp_bus(32'h100, 1'b0, 4'hF, 32'h0, 1);
    exp_ack(1'b1, 32'h1234_5678, 1'b0);
    d_xfer(1'b0, 32'h100, 32'h0, 4'hF, 50);
    @(negedge clk);
    expect_eq("stall_mem_after", 64'(stall_req_mem), 64'd0);

    // Both requesters continuously: D, D, I, D, D, I
    slave_echo = 1'b1;
    exp_bus(32'h200, 1'b0, 4'hF, 32'h0, 1); exp_ack(1'b1, 32'h200 ^ ECHO_KEY, 1'b0);
    exp_bus(32'h204, 1'b0, 4'hF, 32'h0, 1); exp_ack(1'b1, 32'h204 ^ ECHO_KEY, 1'b0);
    exp_bus(32'h1000, 1'b0, 4'hF, 32'h0, 1); exp_ack(1'b0, 32'h1000 ^ ECHO_KEY, 1'b0);
    exp_bus(32'h208, 1'b0, 4'hF, 32'h0, 1); exp_ack(1'b1, 32'h208 ^ ECHO_KEY, 1'b0);
    exp_bus(32'h20C, 1'b0, 4'hF, 32'h0, 1); exp_ack(1'b1, 32'h20C ^ ECHO_KEY, 1'b0);
    exp_bus(32'h1004, 1'b0, 4'hF, 32'h0, 1); exp_ack(1'b0, 32'h1004 ^ ECHO_KEY, 1'b0);
    fork
      for (int k = 0; k < 4; k++) d_xfer(1'b0, 32'h200 + 32'(4 * k), 32'h0, 4'hF, 50);
      for (int k = 0; k < 2; k++) i_xfer(32'h1000 + 32'(4 * k), 100);
    join
    @(negedge clk);
    expect_eq("d_rdata_hold", 64'(d_rdata), 64'(32'h20C ^ ECHO_KEY));

    // Partial D write with 5 wait states
    slave_echo = 1'b0; slave_data = 32'h0BAD_F00D; slave_wait = 5;
    exp_bus(32'h180, 1'b1, 4'b0011, 32'hAABB_CCDD, 6);
    exp_ack(1'b1, 32'h0BAD_F00D, 1'b0);
    d_xfer(1'b1, 32'h180, 32'hAABB_CCDD, 4'b0011, 50);
    slave_wait = 0;
    repeat (2) @(negedge clk);

    // Spurious s_ack while idle
    @(posedge clk);
    #1 spur_ack = 1'b1;
    repeat (3) @(negedge clk);
    expect_eq("spur_s_cyc", 64'(s_cyc), 64'd0);
    expect_eq("spur_acks", 64'({d_ack, i_ack}), 64'd0);
    #1 spur_ack = 1'b0;
    repeat (2) @(negedge clk);
    expect_eq("spur_acks_after", 64'({d_ack, i_ack}), 64'd0);
    slave_echo = 1'b1;
    exp_bus(32'h300, 1'b0, 4'hF, 32'h0, 1);
    exp_ack(1'b1, 32'h300 ^ ECHO_KEY, 1'b0);
    d_xfer(1'b0, 32'h300, 32'h0, 4'hF, 50);

    // Reset during an I grant, then re-grant of the held request
    slave_en = 1'b0;
    exp_bus(32'h3000, 1'b0, 4'hF, 32'h0, -1);
    exp_bus(32'h3000, 1'b0, 4'hF, 32'h0, 1);
    exp_ack(1'b0, 32'h3000 ^ ECHO_KEY, 1'b0);
    @(posedge clk);
    #1 i_req = 1'b1; i_addr = 32'h3000;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_cyc && n < 20);
    expect_eq("rst_test_grant", 64'(s_cyc), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    expect_eq("midrst_s_cyc", 64'(s_cyc), 64'd0);
    expect_eq("midrst_i_ack", 64'(i_ack), 64'd0);
    expect_eq("midrst_stall_if", 64'(stall_req_if), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    slave_en = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!i_ack && n < 50);
    expect_eq("regrant_i_ack", 64'(i_ack), 64'd1);
    i_req = 1'b0;

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    // Slave never answers: watchdog ends the grant after 255 cycles
    slave_en = 1'b0;
    exp_bus(32'h400, 1'b0, 4'hF, 32'h0, 255);
    exp_ack(1'b1, 32'hDEAD_BEEF, 1'b1);
    d_xfer(1'b0, 32'h400, 32'h0, 4'hF, 400);
    slave_en = 1'b1;
    exp_bus(32'h404, 1'b0, 4'hF, 32'h0, 1);
    exp_ack(1'b1, 32'h404 ^ ECHO_KEY, 1'b0);
    d_xfer(1'b0, 32'h404, 32'h0, 4'hF, 50);
`endif

    repeat (4) @(negedge clk);
    expect_eq("ack_q_drained", 64'(ack_q.size()), 64'd0);
    expect_eq("bus_q_drained", 64'(bus_q.size()), 64'd0);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
